alu_nibble_serial: RTL
======================

# alu_nibble_serial

Parametrised, multi-cycle successor to the team's 4-bit ALU slice. Processes a WIDTH-bit operation one 4-bit slice per clock, least-significant slice first, rippling the carry through a registered carry bit. Sits between the datapath issue logic and writeback, with valid/ready handshakes on both sides. Adds proper signed less-than, NOR, and backpressure, none of which the combinational slice has.

## Interface

- WIDTH, 16, operand/result width; multiple of 4, minimum 8; N = WIDTH/4 slices
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  high only in IDLE
- a  input  WIDTH  operand A, two's complement
- b  input  WIDTH  operand B, two's complement
- op  input  3  000 AND, 001 OR, 100 NOR, 010 ADD, 110 SUB, 111 SLT; other codes are undefined ops
- out_valid  output  1  result valid, high only in DONE
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- cout  output  1  carry out of MSB, ADD/SUB/SLT only, else 0
- overflow  output  1  signed overflow, ADD/SUB/SLT only, else 0
- set  output  1  signed a<b, SLT/SUB only, else 0
- zero  output  1  final result == 0

## Operation

- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture a, b and op. Clear the slice index k to 0. Set the carry register to 1 for SUB/SLT, else 0. Go to BUSY.
- BUSY: each edge computes slice k, i.e. bits [4k+3:4k], from the captured operands.
  - Logic ops are bitwise.
  - ADD is a+b+carry. SUB/SLT are a+~b+carry.
  - The nibble is written into the result register. The carry register takes the slice carry-out. k increments.
- After slice N-1: compute flags from the MSB slice and go to DONE.
  - cout = final carry.
  - overflow = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' = ~b for SUB/SLT.
  - set = sum[MSB] XOR overflow.
  - SLT replaces result with {0…0, set}.
  - zero is evaluated on the final result, after any SLT substitution.
- Undefined op: result 0, zero=1, cout/overflow/set=0. Timing is the same as a defined op.
- DONE: out_valid=1. result and all flags are held stable. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. Captured operands are unaffected by input changes after acceptance.
- Reset (async, any state): state IDLE, in_ready=1, out_valid=0, result=0, cout/overflow/set/zero=0, k=0, carry=0. An in-flight operation is discarded and produces no output.

## Timing

- Accept edge T0. Slices 0..N-1 are processed on edges T1..TN. out_valid is high from edge TN (latency N cycles; 4 for WIDTH=16).
- Output handshake completes on the first edge with out_valid&&out_ready. in_ready rises on that same edge.
- Minimum issue interval is N+2 cycles: N BUSY, 1 DONE, 1 IDLE.
- in_ready and out_valid are decoded directly from state registers, with no combinational path from inputs.
- result bits are undefined while BUSY; the bench samples them only when out_valid=1.

## Test plan

- ADD 0x7FFF + 0x0001 → result 0x8000, overflow=1, cout=0, zero=0, set=0. out_valid is first high 4 cycles after the accept edge.
- SUB 0x1234 − 0x1234 → result 0x0000, zero=1, cout=1, overflow=0, set=0. Also ADD 0xFFFF + 0x0001 → result 0x0000, cout=1, zero=1.
- SLT cases:
  - a=0x8000, b=0x0001 → result 0x0001, set=1.
  - a=0x7FFF, b=0x8000 → result 0x0000, set=0, overflow=1.
  - a=b=0x0005 → result 0x0000, zero=1.
- Logic ops with a=0xF0F0, b=0xFF00:
  - AND → 0xF000.
  - OR → 0xFFF0.
  - NOR → 0x000F.
  - In all three cases cout=overflow=set=0. op=011 → result 0x0000, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, result and flags remain constant and in_ready stays 0. A new in_valid pulse during this window is not accepted. out_ready=1 returns the block to IDLE, and the next request is accepted normally.
- Reset: assert rst_n=0 mid-BUSY (after slice 1) → out_valid=0, in_ready=1 and result=0 immediately without waiting for a clock edge. After release, an ADD 0x0003 + 0x0004 completes with result 0x0007 in 4 cycles.

Source files
------------

// File: rtl/alu_nibble_serial.sv
// ----------------------------------------------------------------------------
// alu_nibble_serial : WIDTH-bit ALU evaluated one 4-bit slice per clock, LSB first
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_nibble_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             set,
  output logic             zero
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;
  logic             set_q, set_d;
  logic             zero_q, zero_d;

  logic [KW+1:0]    base;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       sum;
  logic [3:0]       nib;
  logic             is_sub;
  logic             is_arith;
  logic             slice_ovf;

  // Slice datapath: operands come only from the captured copies.
  assign base      = {k_q, 2'b00};
  assign is_sub    = (op_q == OP_SUB) || (op_q == OP_SLT);
  assign is_arith  = is_sub || (op_q == OP_ADD);
  assign a_nib     = a_q[base +: 4];
  assign b_nib     = is_sub ? ~b_q[base +: 4] : b_q[base +: 4];
  assign sum       = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
  assign slice_ovf = (a_nib[3] == b_nib[3]) && (sum[3] != a_nib[3]);

  always_comb begin
    case (op_q)
      OP_AND:                 nib = a_nib & b_nib;
      OP_OR:                  nib = a_nib | b_nib;
      OP_NOR:                 nib = ~(a_nib | b_nib);
      OP_ADD, OP_SUB, OP_SLT: nib = sum[3:0];
      default:                nib = 4'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    set_d      = set_q;
    zero_d     = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          k_d     = '0;
          carry_d = (op == OP_SUB) || (op == OP_SLT);
          state_d = BUSY;
        end
      end

      BUSY: begin
        result_d[base +: 4] = nib;
        carry_d             = sum[4];
        if (k_q == K_LAST) begin
          // The MSB slice is being processed: its carry/sign bits give the flags.
          cout_d     = is_arith & sum[4];
          overflow_d = is_arith & slice_ovf;
          set_d      = is_sub & (sum[3] ^ slice_ovf);
          if (op_q == OP_SLT) begin
            result_d = {{(WIDTH-1){1'b0}}, sum[3] ^ slice_ovf};
          end
          zero_d  = (result_d == '0);
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 3'b000;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      set_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      set_q      <= set_d;
      zero_q     <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign set       = set_q;
  assign zero      = zero_q;

endmodule

`default_nettype wire
